// File: rtl/servo_axis_ctrl.sv
// ---------------------------------------------------------------------------
// servo_axis_ctrl
//   N-channel servo controller. Once per PWM frame every channel latches a
//   target from either the memory or the accelerometer bus, clamps it to
//   POS_MAX, moves its current position toward it, and drives a framed PWM
//   whose high time is MIN_DC + pos*DC_PER_LSB cycles.
//
//   Build option: SERVO_SLEW_EN
//     defined   -> position moves at most STEP per frame toward the target
//     undefined -> position jumps to the target at every frame boundary
//
// Ports
//   clk           in   system clock
//   rst           in   asynchronous active-high reset
//   enable        in   1 = run frames, 0 = hold (counter parked at 0, PWM low)
//   select_source in   1 = pos_accel, 0 = pos_mem (sampled at frame wrap)
//   pos_mem       in   N_CH*POS_W memory targets, channel i at [i*POS_W +: POS_W]
//   pos_accel     in   N_CH*POS_W accelerometer targets, same packing
//   pwm_out       out  N_CH servo PWM bits
//   pos_cur       out  N_CH*POS_W current positions, same packing
//   frame_tick    out  one-cycle pulse on the cycle a new frame starts
//   at_target     out  1 when every channel sits on its latched target
// ---------------------------------------------------------------------------
module servo_axis_ctrl #(
    parameter int N_CH       = 3,
    parameter int POS_W      = 10,
    parameter int POS_MAX    = 1000,
    parameter int POS_RST    = 500,
    parameter int PERIOD     = 1_000_000,
    parameter int MIN_DC     = 25_000,
    parameter int DC_PER_LSB = 100,
    parameter int STEP       = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable,
    input  logic                   select_source,
    input  logic [N_CH*POS_W-1:0]  pos_mem,
    input  logic [N_CH*POS_W-1:0]  pos_accel,
    output logic [N_CH-1:0]        pwm_out,
    output logic [N_CH*POS_W-1:0]  pos_cur,
    output logic                   frame_tick,
    output logic                   at_target
);

    localparam int CNT_W  = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    // Wide enough to hold PERIOD itself, the largest legal duty.
    localparam int DUTY_W = $clog2(PERIOD + 1);
    localparam int DIFF_W = POS_W + 1;

    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(PERIOD - 1);
    localparam logic [POS_W-1:0]         POS_MAX_V = POS_W'(POS_MAX);
    localparam logic [POS_W-1:0]         POS_RST_V = POS_W'(POS_RST);
    localparam logic [DUTY_W-1:0]        MIN_DC_V  = DUTY_W'(MIN_DC);
    localparam logic [DUTY_W-1:0]        DC_LSB_V  = DUTY_W'(DC_PER_LSB);
`ifdef SERVO_SLEW_EN
    localparam logic [POS_W-1:0]         STEP_P    = POS_W'(STEP);
    localparam logic signed [DIFF_W-1:0] STEP_D    = DIFF_W'(STEP);
`endif

    logic [CNT_W-1:0]  cnt;
    logic              wrap;
    logic [POS_W-1:0]  pos_r   [N_CH];
    logic [POS_W-1:0]  src_sel [N_CH];
    logic [POS_W-1:0]  tgt_nx  [N_CH];
    logic [POS_W-1:0]  pos_nx  [N_CH];
    logic [DUTY_W-1:0] duty    [N_CH];
    logic signed [DIFF_W-1:0] diff [N_CH];
    logic              all_match;

    assign wrap = enable && (cnt == CNT_LAST);

    // Next-frame target/position for every channel. The latched target is
    // only observable through at_target, which is registered on the same
    // wrap edge from these values, so it is not kept as separate state.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        all_match = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            src_sel[i] = select_source ? pos_accel[i*POS_W +: POS_W]
                                       : pos_mem[i*POS_W +: POS_W];
            tgt_nx[i]  = (src_sel[i] > POS_MAX_V) ? POS_MAX_V : src_sel[i];
            // Unsigned operands zero-extended by one bit so the difference
            // keeps its sign without wrapping.
            diff[i]    = signed'({1'b0, tgt_nx[i]}) - signed'({1'b0, pos_r[i]});
`ifdef SERVO_SLEW_EN
            if (diff[i] > STEP_D) begin
                pos_nx[i] = pos_r[i] + STEP_P;
            end else if (diff[i] < -STEP_D) begin
                pos_nx[i] = pos_r[i] - STEP_P;
            end else begin
                pos_nx[i] = tgt_nx[i];
            end
`else
            pos_nx[i] = tgt_nx[i];
`endif
            duty[i]   = MIN_DC_V + DUTY_W'(pos_r[i]) * DC_LSB_V;
            all_match = all_match && (pos_nx[i] == tgt_nx[i]);
            pos_cur[i*POS_W +: POS_W] = pos_r[i];
        end
    end

    // NOTE: the position array is reset explicitly because it is control
    // state that must restart at centre, not a data memory.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt        <= '0;
            pwm_out    <= '0;
            frame_tick <= 1'b0;
            at_target  <= 1'b0;
            for (int i = 0; i < N_CH; i++) begin
                pos_r[i] <= POS_RST_V;
            end
        end else if (!enable) begin
            // Hold: counter parked so re-enable starts a full frame.
            cnt        <= '0;
            pwm_out    <= '0;
            frame_tick <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            cnt        <= wrap ? '0 : cnt + 1'b1;
            frame_tick <= wrap;
            // Compare uses the position that is current during this cycle;
            // at the wrap edge cnt is PERIOD-1, so the new position first
            // applies to the cnt=0 compare of the next frame.
            for (int i = 0; i < N_CH; i++) begin
                pwm_out[i] <= (DUTY_W'(cnt) < duty[i]);
            end
            if (wrap) begin
                at_target <= all_match;
                for (int i = 0; i < N_CH; i++) begin
                    pos_r[i] <= pos_nx[i];
                end
            end
        end
    end

endmodule

// File: tb/tb_servo_axis_ctrl.sv
// ---------------------------------------------------------------------------
// tb_servo_axis_ctrl
//   Self-checking bench for servo_axis_ctrl. A reference model computes, at
//   the start of each frame, the positions and at_target expected after the
//   coming wrap and the high time expected during the frame; these are
//   queued and compared when the frame ends. Expectations follow the
//   SERVO_SLEW_EN setting of the build (slew or one-frame jump).
// ---------------------------------------------------------------------------
module tb_servo_axis_ctrl;

    localparam int N_CH       = 3;
    localparam int POS_W      = 10;
    localparam int POS_MAX    = 100;
    localparam int POS_RST    = 50;
    localparam int PERIOD     = 200;
    localparam int MIN_DC     = 20;
    localparam int DC_PER_LSB = 1;
    localparam int STEP       = 10;

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic                  enable = 1'b1;
    logic                  select_source = 1'b0;
    logic [N_CH*POS_W-1:0] pos_mem = '0;
    logic [N_CH*POS_W-1:0] pos_accel = '0;
    logic [N_CH-1:0]       pwm_out;
    logic [N_CH*POS_W-1:0] pos_cur;
    logic                  frame_tick;
    logic                  at_target;

    servo_axis_ctrl #(
        .N_CH(N_CH), .POS_W(POS_W), .POS_MAX(POS_MAX), .POS_RST(POS_RST),
        .PERIOD(PERIOD), .MIN_DC(MIN_DC), .DC_PER_LSB(DC_PER_LSB), .STEP(STEP)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .select_source(select_source),
        .pos_mem(pos_mem), .pos_accel(pos_accel), .pwm_out(pwm_out),
        .pos_cur(pos_cur), .frame_tick(frame_tick), .at_target(at_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N_CH-1:0][15:0] pos;
        logic                  at;
        logic [N_CH-1:0][15:0] high;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   m_pos[N_CH];
    int   m_at;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic int cur_pos(input int ch);
        return int'(pos_cur[ch*POS_W +: POS_W]);
    endfunction

    function automatic int sel_in(input int ch);
        return select_source ? int'(pos_accel[ch*POS_W +: POS_W])
                             : int'(pos_mem[ch*POS_W +: POS_W]);
    endfunction

    task automatic set_mem(input int a, input int b, input int c);
        pos_mem = {POS_W'(c), POS_W'(b), POS_W'(a)};
    endtask

    task automatic set_accel(input int a, input int b, input int c);
        pos_accel = {POS_W'(c), POS_W'(b), POS_W'(a)};
    endtask

    task automatic model_reset();
        for (int ch = 0; ch < N_CH; ch++) m_pos[ch] = POS_RST;
        m_at = 0;
    endtask

    // Model of one wrap edge using the inputs as currently driven.
    task automatic model_wrap();
        exp_t e;
        int   t;
        int   all;
        all = 1;
        for (int ch = 0; ch < N_CH; ch++) begin
            e.high[ch] = 16'(MIN_DC + m_pos[ch] * DC_PER_LSB);
            t = sel_in(ch);
            if (t > POS_MAX) t = POS_MAX;
`ifdef SERVO_SLEW_EN
            if (t > m_pos[ch]) m_pos[ch] = (t - m_pos[ch] > STEP) ? m_pos[ch] + STEP : t;
            else               m_pos[ch] = (m_pos[ch] - t > STEP) ? m_pos[ch] - STEP : t;
`else
            m_pos[ch] = t;
`endif
            if (m_pos[ch] != t) all = 0;
            e.pos[ch] = 16'(m_pos[ch]);
        end
        e.at = (all != 0);
        m_at = all;
        sb.push_back(e);
    endtask

    // Runs one full frame starting just after a frame start (cnt=0). When
    // glitch is set, both sources of channel 0 are disturbed mid-frame and
    // restored before the wrap; the disturbance must have no effect.
    task automatic run_frame(input string name, input bit glitch = 1'b0);
        int   high[N_CH];
        int   early;
        exp_t e;
        logic [N_CH*POS_W-1:0] keep_m, keep_a;
        model_wrap();
        early = 0;
        for (int ch = 0; ch < N_CH; ch++) high[ch] = 0;
        for (int k = 1; k <= PERIOD; k++) begin
            @(negedge clk);
            if (glitch && k == 50) begin
                keep_m = pos_mem;
                keep_a = pos_accel;
                pos_mem[POS_W-1:0]   = '0;
                pos_accel[POS_W-1:0] = '0;
            end
            if (glitch && k == 60) begin
                pos_mem   = keep_m;
                pos_accel = keep_a;
            end
            for (int ch = 0; ch < N_CH; ch++) high[ch] += int'(pwm_out[ch]);
            if (k < PERIOD && frame_tick) early++;
        end
        check({name, " tick_early"}, early, 0);
        check({name, " tick"}, int'(frame_tick), 1);
        if (sb.size() == 0) begin
            check({name, " scoreboard_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            for (int ch = 0; ch < N_CH; ch++) begin
                check($sformatf("%s high%0d", name, ch), high[ch], int'(e.high[ch]));
                check($sformatf("%s pos%0d", name, ch), cur_pos(ch), int'(e.pos[ch]));
            end
            check({name, " at_target"}, int'(at_target), int'(e.at));
        end
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, " pwm"}, int'(pwm_out), 0);
        check({name, " tick"}, int'(frame_tick), 0);
        check({name, " at"}, int'(at_target), 0);
        for (int ch = 0; ch < N_CH; ch++)
            check($sformatf("%s pos%0d", name, ch), cur_pos(ch), POS_RST);
    endtask

    initial begin
        int pwm_seen, tick_seen, pos_moved, at_moved;
        int frozen[N_CH];
        int at_hold;

        // Power-on reset, everything parked at centre.
        set_mem(50, 50, 50);
        set_accel(50, 50, 50);
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        model_reset();
        rst = 1'b0;

        // Centre position: 70-cycle high time, target reached at first wrap.
        run_frame("centre");

        // Memory source ramps ch0 to the ceiling; one frame has a glitch.
        set_mem(100, 50, 50);
        run_frame("mem_r1");
        run_frame("mem_r2", 1'b1);
        run_frame("mem_r3");
        run_frame("mem_r4");
        run_frame("mem_r5");

        // Accelerometer source with an out-of-range ch1 target (clamped).
        set_accel(100, 1023, 50);
        select_source = 1'b1;
        for (int f = 0; f < 5; f++) run_frame($sformatf("acc_r%0d", f + 1));

        // ch2 heads for 0, then a reset hits mid-frame.
        select_source = 1'b0;
        set_mem(100, 100, 0);
        run_frame("low_r1");
        run_frame("low_r2");
        repeat (80) @(negedge clk);
        #2 rst = 1'b1;
        #1 check_reset_outputs("mid_rst");
        @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        model_reset();
        rst = 1'b0;
        run_frame("post_rst_r1");
        run_frame("post_rst_r2");

        // Hold for 500 cycles in the middle of a frame.
        repeat (37) @(negedge clk);
        enable = 1'b0;
        for (int ch = 0; ch < N_CH; ch++) frozen[ch] = cur_pos(ch);
        at_hold = int'(at_target);
        pwm_seen = 0; tick_seen = 0; pos_moved = 0; at_moved = 0;
        @(negedge clk);
        for (int k = 0; k < 500; k++) begin
            @(negedge clk);
            if (pwm_out != '0) pwm_seen++;
            if (frame_tick) tick_seen++;
            if (int'(at_target) != at_hold) at_moved++;
            for (int ch = 0; ch < N_CH; ch++)
                if (cur_pos(ch) != frozen[ch]) pos_moved++;
        end
        check("hold pwm_high_cycles", pwm_seen, 0);
        check("hold ticks", tick_seen, 0);
        check("hold pos_changes", pos_moved, 0);
        check("hold at_changes", at_moved, 0);
        check("hold at_value", at_hold, m_at);
        enable = 1'b1;
        run_frame("reen_r1");
        run_frame("reen_r2");

        check("scoreboard_left", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
